cga_mic_incount_n: RTL and testbench

//  Parametrised loadable up/down counter for the MIC control-store write-address path.

---
 rtl/cga_mic_pkg.sv | 15 +
 rtl/cga_mic_incount_n.sv | 87 ++++++++
 tb/tb_cga_mic_incount_n.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cga_mic_pkg.sv
// cga_mic_pkg: shared types and defaults for the MIC control-store address path.
//   cnt_dir_t  : count direction as seen on DN (0 = up, 1 = down)
//   CSWA_W     : default width of the control-store write-address counter
//   CSWA_MAXV  : default highest count value of that counter
package cga_mic_pkg;

  typedef enum logic {
    CNT_UP = 1'b0,
    CNT_DN = 1'b1
  } cnt_dir_t;

  localparam int CSWA_W    = 2;
  localparam int CSWA_MAXV = 3;

endpackage

// File: rtl/cga_mic_incount_n.sv
// cga_mic_incount_n: loadable up/down counter for the MIC control-store write-address path.
// Counts 0..MAXV, either wrapping or saturating at the ends, with a combinational
// terminal-count look-ahead for cascading and a sticky wrap/saturate-hit flag.
// Ports:
//   MCLK   in   system clock, rising edge active
//   MRN    in   asynchronous active-low master reset
//   LWCAN  in   0 = load CD this clock, 1 = count mode
//   EC     in   count enable (count mode only)
//   DN     in   direction, 0 = up, 1 = down
//   CD     in   W-bit parallel load data, true polarity (clamped to MAXV)
//   CSWAN  out  current count, active-low
//   TCN    out  terminal count, active-low, combinational
//   WRAPF  out  sticky wrap/saturate-hit flag, cleared by load or reset
module cga_mic_incount_n
  import cga_mic_pkg::*;
#(
  parameter int W        = CSWA_W,
  parameter int MAXV     = (1 << W) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic         MCLK,
  input  logic         MRN,
  input  logic         LWCAN,
  input  logic         EC,
  input  logic         DN,
  input  logic [W-1:0] CD,
  output logic [W-1:0] CSWAN,
  output logic         TCN,
  output logic         WRAPF
);

  localparam logic [W-1:0] MAX_V = W'(MAXV);

  // Out-of-range load data clamps to the top value rather than folding modulo.
  function automatic logic [W-1:0] clampLoad(input logic [W-1:0] d);
    return (d > MAX_V) ? MAX_V : d;
  endfunction

  logic [W-1:0] cnt;
  logic         wrapf;
  logic [W-1:0] cntNxt;
  logic         wrapNxt;
  logic         atEnd;
  cnt_dir_t     dir;

  assign dir = cnt_dir_t'(DN);

  // End of range in the current direction: the next enabled count wraps or saturates.
  assign atEnd = (dir == CNT_DN) ? (cnt == '0) : (cnt == MAX_V);

  always_comb begin
    cntNxt  = cnt;
    wrapNxt = wrapf;
    if (!LWCAN) begin
      cntNxt  = clampLoad(CD);
      wrapNxt = 1'b0;
    end else if (EC) begin
      if (atEnd) begin
        wrapNxt = 1'b1;
        // Saturating: cnt already sits on the end value, so holding it is the saturation.
        if (!SATURATE) begin
          cntNxt = (dir == CNT_DN) ? MAX_V : '0;
        end
      end else begin
        cntNxt = (dir == CNT_DN) ? (cnt - W'(1)) : (cnt + W'(1));
      end
    end
  end

  // State register: next-state mux output captured on MCLK, cleared at once on ~MRN
  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      cnt   <= '0;
      wrapf <= 1'b0;
    end else begin
      cnt   <= cntNxt;
      wrapf <= wrapNxt;
    end
  end

  // Output inversion and look-ahead. TCN is forced inactive while reset holds the
  // counter, so a cascaded stage never sees a spurious enable during reset.
  assign CSWAN = ~cnt;
  assign WRAPF = wrapf;
  assign TCN   = ~(MRN & LWCAN & EC & atEnd);

endmodule

// File: tb/tb_cga_mic_incount_n.sv
module tb_cga_mic_incount_n;

  logic MCLK = 1'b0;
  logic MRN  = 1'b0;
  always #5 MCLK = ~MCLK;

  // Three single instances: 0 = W4/MAXV9/wrap, 1 = W4/MAXV9/saturate, 2 = W4/MAXV15/wrap
  logic       lw[3];
  logic       ec[3];
  logic       dn[3];
  logic [3:0] cd[3];
  logic [3:0] cswan[3];
  logic       tcn[3];
  logic       wrf[3];

  int maxv[3] = '{9, 9, 15};
  int sat[3]  = '{0, 1, 0};

  cga_mic_incount_n #(.W(4), .MAXV(9), .SATURATE(1'b0)) dA (
    .MCLK(MCLK), .MRN(MRN), .LWCAN(lw[0]), .EC(ec[0]), .DN(dn[0]), .CD(cd[0]),
    .CSWAN(cswan[0]), .TCN(tcn[0]), .WRAPF(wrf[0]));
  cga_mic_incount_n #(.W(4), .MAXV(9), .SATURATE(1'b1)) dB (
    .MCLK(MCLK), .MRN(MRN), .LWCAN(lw[1]), .EC(ec[1]), .DN(dn[1]), .CD(cd[1]),
    .CSWAN(cswan[1]), .TCN(tcn[1]), .WRAPF(wrf[1]));
  cga_mic_incount_n #(.W(4), .MAXV(15), .SATURATE(1'b0)) dC (
    .MCLK(MCLK), .MRN(MRN), .LWCAN(lw[2]), .EC(ec[2]), .DN(dn[2]), .CD(cd[2]),
    .CSWAN(cswan[2]), .TCN(tcn[2]), .WRAPF(wrf[2]));

  // Two-stage cascade of default 2-bit counters
  logic       ecCas;
  logic [1:0] csL, csH;
  logic       tcnL, tcnH, wrL, wrH, ecH;
  assign ecH = ~tcnL;

  cga_mic_incount_n dL (
    .MCLK(MCLK), .MRN(MRN), .LWCAN(1'b1), .EC(ecCas), .DN(1'b0), .CD(2'b00),
    .CSWAN(csL), .TCN(tcnL), .WRAPF(wrL));
  cga_mic_incount_n dH (
    .MCLK(MCLK), .MRN(MRN), .LWCAN(1'b1), .EC(ecH), .DN(1'b0), .CD(2'b00),
    .CSWAN(csH), .TCN(tcnH), .WRAPF(wrH));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: plain integer rules for one counting edge
  function automatic int nextCnt(input int c, input logic l, input logic e, input logic d,
                                 input int din, input int mx, input int st);
    if (!l) return (din > mx) ? mx : din;
    if (!e) return c;
    if (!d) return (c < mx) ? c + 1 : (st != 0 ? mx : 0);
    return (c > 0) ? c - 1 : (st != 0 ? 0 : mx);
  endfunction

  function automatic int nextWr(input int c, input int wr, input logic l, input logic e,
                                input logic d, input int mx);
    if (!l) return 0;
    if (e && ((!d && c == mx) || (d && c == 0))) return 1;
    return wr;
  endfunction

  int mCnt[3];
  int mWr[3];
  int cc;   // combined cascade value: enabled edges since reset, mod 16

  always @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      for (int i = 0; i < 3; i++) begin
        mCnt[i] <= 0;
        mWr[i]  <= 0;
      end
      cc <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mCnt[i] <= nextCnt(mCnt[i], lw[i], ec[i], dn[i], int'(cd[i]), maxv[i], sat[i]);
        mWr[i]  <= nextWr(mCnt[i], mWr[i], lw[i], ec[i], dn[i], maxv[i]);
      end
      if (ecCas) cc <= (cc + 1) % 16;
    end
  end

  // Per-cycle compare, 1 time unit after the edge; inputs change at +2
  always begin
    @(posedge MCLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cswan%0d", i), int'(cswan[i]), (~mCnt[i]) & 15);
      chk($sformatf("wrapf%0d", i), int'(wrf[i]), mWr[i]);
      chk($sformatf("tcn%0d", i), int'(tcn[i]),
          (MRN && lw[i] && ec[i] && (dn[i] ? mCnt[i] == 0 : mCnt[i] == maxv[i])) ? 0 : 1);
    end
    chk("cascade", int'({~csH, ~csL}), cc);
    chk("tcnLow", int'(tcnL), (MRN && ecCas && (cc % 4) == 3) ? 0 : 1);
  end

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      lw[i] = 1'b1; ec[i] = 1'b0; dn[i] = 1'b0; cd[i] = 4'h0;
    end
    ecCas = 1'b0;
    // Reset with instance 0 looking like a down-count at zero: TCN must stay high
    ec[0] = 1'b1; dn[0] = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rstCswan", int'(cswan[i]), 15);
      chk("rstWrapf", int'(wrf[i]), 0);
      chk("rstTcn", int'(tcn[i]), 1);
    end
    ec[0] = 1'b0; dn[0] = 1'b0;
    @(negedge MCLK);
    MRN = 1'b1;

    // T2: MAXV=9 wrap, load 7, count up 8,9,0,1
    lw[0] = 1'b0; cd[0] = 4'd7; tick();
    chk("t2load", int'(cswan[0]), 4'h8);
    lw[0] = 1'b1; ec[0] = 1'b1;
    tick(); chk("t2c8", int'(cswan[0]), 4'h7); chk("t2tcn8", int'(tcn[0]), 1);
    tick(); chk("t2c9", int'(cswan[0]), 4'h6); chk("t2tcn9", int'(tcn[0]), 0);
    chk("t2wr9", int'(wrf[0]), 0);
    tick(); chk("t2c0", int'(cswan[0]), 4'hF); chk("t2wr0", int'(wrf[0]), 1);
    tick(); chk("t2c1", int'(cswan[0]), 4'hE); chk("t2wr1", int'(wrf[0]), 1);
    ec[0] = 1'b0;

    // T3: saturating down from 1
    lw[1] = 1'b0; cd[1] = 4'd1; tick();
    lw[1] = 1'b1; dn[1] = 1'b1; ec[1] = 1'b1;
    tick(); chk("t3c0a", int'(cswan[1]), 4'hF); chk("t3tcn", int'(tcn[1]), 0);
    chk("t3wra", int'(wrf[1]), 0);
    tick(); chk("t3c0b", int'(cswan[1]), 4'hF); chk("t3wrb", int'(wrf[1]), 1);
    tick(); chk("t3c0c", int'(cswan[1]), 4'hF); chk("t3tcnc", int'(tcn[1]), 0);
    ec[1] = 1'b0; dn[1] = 1'b0;

    // T4: clamp on load, load beats count
    lw[0] = 1'b0; cd[0] = 4'hC; tick();
    chk("t4clamp", int'(cswan[0]), 4'h6);
    ec[0] = 1'b1; cd[0] = 4'd3; tick();
    chk("t4loadWins", int'(cswan[0]), 4'hC);
    lw[0] = 1'b1; ec[0] = 1'b0;

    // T5: load clears wrapf; hold with EC=0
    lw[0] = 1'b0; cd[0] = 4'd9; tick();
    lw[0] = 1'b1; ec[0] = 1'b1; tick();
    chk("t5wrap", int'(wrf[0]), 1);
    lw[0] = 1'b0; cd[0] = 4'd0; ec[0] = 1'b0; tick();
    chk("t5clr", int'(wrf[0]), 0); chk("t5c0", int'(cswan[0]), 4'hF);
    lw[0] = 1'b1; ec[0] = 1'b1; dn[0] = 1'b1; tick();
    chk("t5dnwrap", int'(cswan[0]), 4'h6); chk("t5wr", int'(wrf[0]), 1);
    ec[0] = 1'b0;
    repeat (5) begin
      tick();
      chk("t5hold", int'(cswan[0]), 4'h6);
      chk("t5holdWr", int'(wrf[0]), 1);
      chk("t5holdTcn", int'(tcn[0]), 1);
    end
    dn[0] = 1'b0;

    // T1: async reset mid-count at 9 on the 4-bit full-range counter
    lw[2] = 1'b0; cd[2] = 4'd5; tick();
    lw[2] = 1'b1; ec[2] = 1'b1;
    repeat (4) tick();
    chk("t1c9", int'(cswan[2]), 4'h6);
    MRN = 1'b0;
    #1;
    chk("t1rst", int'(cswan[2]), 4'hF);
    chk("t1wr", int'(wrf[2]), 0);
    chk("t1tcn", int'(tcn[2]), 1);
    ec[2] = 1'b0;
    @(negedge MCLK);
    MRN = 1'b1;

    // T6: cascade 0..15 then 0
    ecCas = 1'b1;
    repeat (15) tick();
    chk("t6at15", int'({~csH, ~csL}), 15);
    tick();
    chk("t6wrap", int'({~csH, ~csL}), 0);

    // Randomized traffic with occasional off-edge reset pulses
    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        lw[i] = ($urandom % 8) != 0;
        ec[i] = ($urandom % 4) != 0;
        dn[i] = ($urandom % 2) != 0;
        cd[i] = 4'($urandom % 16);
      end
      ecCas = ($urandom % 3) != 0;
      if (($urandom % 60) == 0) begin
        MRN = 1'b0;
        #4;
        MRN = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
